// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
//   Shared definitions for the seven-segment scanner:
//     - FONT        : 16-entry hex font, {a,b,c,d,e,f,g}, MSB = a, 1 = lit
//     - SEG_A..SEG_G: bit positions of each segment inside a font word
//     - idx_width() : digit index width, $clog2(digits) but never below 1
// -----------------------------------------------------------------------------
package sevenseg_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] FONT [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  // A single-digit display still needs a 1-bit index register.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_font.sv
// -----------------------------------------------------------------------------
// sevenseg_font
//   Purely combinational hex nibble -> seven-segment decoder.
//   Ports:
//     nibble  in  4  hex value 0..F
//     segs    out 7  {a,b,c,d,e,f,g}, MSB = a, 1 = lit
// -----------------------------------------------------------------------------
module sevenseg_font
  import sevenseg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] segs
);

  assign segs = FONT[nibble];

endmodule

// File: rtl/sevenseg_scan.sv
// -----------------------------------------------------------------------------
// sevenseg_scan
//   Time-multiplexed driver for a common-cathode N-digit seven-segment display
//   with per-digit decimal points and blanking, PWM brightness, a one-clock
//   dead time at every slot boundary and frame-coherent input snapshots.
//
//   Parameters:
//     DIGITS   number of digits, 1..8
//     PRE_W    slot counter width; each digit slot lasts 2^PRE_W clocks
//     BRIGHT_W brightness width; must not exceed PRE_W-1
//
//   Ports:
//     clk          system clock
//     rst_n        synchronous active-low reset
//     datain       hex nibbles, digit 0 = most significant nibble
//     dp_in        decimal point per digit (bit i = digit i)
//     blank        force digit i dark when bit i = 1
//     bright       PWM on-time level, all-ones = maximum, sampled live
//     grounds      active-low digit enables, digit i -> grounds[DIGITS-1-i]
//     display      segments {a..g}, 1 = lit
//     dp           decimal point segment, 1 = lit
//     frame_start  one-cycle pulse following each snapshot
//
//   Build option:
//     SEVENSEG_LZB_EN  leading-zero blanking of the snapshot (last digit is
//                      never blanked by it)
// -----------------------------------------------------------------------------
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRE_W    = 16,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   datain,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     grounds,
  output logic [SEG_W-1:0]      display,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int IDX_W = idx_width(DIGITS);

  if (PRE_W < BRIGHT_W + 1) begin : g_bad_widths
    $error("sevenseg_scan: PRE_W must be at least BRIGHT_W+1");
  end

  // ---------------------------------------------------------------------------
  // Scan counters
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] slot_cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_wrap;
  logic             last_digit;
  logic             snapshot;

  assign slot_wrap  = &slot_cnt;
  assign last_digit = (idx == IDX_W'(DIGITS - 1));
  assign snapshot   = (slot_cnt == '0) && (idx == '0);

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      slot_cnt <= slot_cnt + PRE_W'(1);
      if (slot_wrap) begin
        idx <= last_digit ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame snapshot: inputs are only looked at once per frame so a digit never
  // changes while the frame that contains it is being scanned.
  // ---------------------------------------------------------------------------
  logic [3:0]        shad_nib [DIGITS];
  logic [DIGITS-1:0] shad_dp;
  logic [DIGITS-1:0] shad_blank;
  logic [DIGITS-1:0] dark;

`ifdef SEVENSEG_LZB_EN
  logic [DIGITS-1:0] lz_mask;
  logic [DIGITS-1:0] shad_mask;
  logic              lz_run;

  // Run of zero nibbles starting at digit 0; the last digit always shows so a
  // value of zero still reads "0".
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      lz_run = lz_run & (datain[4*(DIGITS-1-i) +: 4] == 4'h0);
      if (i != DIGITS - 1) begin
        lz_mask[i] = lz_run;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shad_mask <= '0;
    end else if (snapshot) begin
      shad_mask <= lz_mask;
    end
  end

  assign dark = shad_blank | shad_mask;
`else
  assign dark = shad_blank;
`endif

  // NOTE: the shadow bank is a handful of flops, not a RAM, so it is reset
  // like any other register and the first frame after reset is well defined.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        shad_nib[i] <= '0;
      end
      shad_dp    <= '0;
      shad_blank <= '0;
    end else if (snapshot) begin
      for (int i = 0; i < DIGITS; i++) begin
        shad_nib[i] <= datain[4*(DIGITS-1-i) +: 4];
      end
      shad_dp    <= dp_in;
      shad_blank <= blank;
    end
  end

  // ---------------------------------------------------------------------------
  // Current-digit selection and on-condition
  // ---------------------------------------------------------------------------
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_dark;
  logic [SEG_W-1:0]  cur_segs;
  logic              digit_on;
  logic [DIGITS-1:0] nxt_grounds;

  // NOTE: every variable assigned here gets a default first, so no path
  // through the loop can leave one unassigned and infer a latch.
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib  = shad_nib[i];
        cur_dp   = shad_dp[i];
        cur_dark = dark[i];
      end
    end
  end

  sevenseg_font u_font (
    .nibble (cur_nib),
    .segs   (cur_segs)
  );

  // Slot count 0 is the dead cycle between digits; the top BRIGHT_W bits of
  // the slot count form the PWM ramp compared against the live brightness.
  assign digit_on = (slot_cnt != '0)
                 && (slot_cnt[PRE_W-1 -: BRIGHT_W] <= bright)
                 && !cur_dark;

  always_comb begin
    nxt_grounds = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_on && (idx == IDX_W'(i))) begin
        nxt_grounds[DIGITS-1-i] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered pins
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grounds     <= '1;
      display     <= '0;
      dp          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      grounds     <= nxt_grounds;
      display     <= digit_on ? cur_segs : '0;
      dp          <= digit_on & cur_dp;
      frame_start <= snapshot;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan
//   Self-checking bench for sevenseg_scan (DIGITS=4, PRE_W=4, BRIGHT_W=2).
//   A reference model tracks elapsed clocks since reset and derives slot,
//   digit and snapshot contents arithmetically; every cycle the DUT pins are
//   compared with it. Directed phases cover scan order, snapshot coherence,
//   brightness, blanking/dp, mid-frame reset and leading zeros, followed by
//   randomized traffic.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan;

  localparam int D    = 4;
  localparam int PW   = 4;
  localparam int BW   = 2;
  localparam int SLOT = 1 << PW;
  localparam int STEP = 1 << (PW - BW);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*D-1:0] datain;
  logic [D-1:0]  dp_in;
  logic [D-1:0]  blank;
  logic [BW-1:0] bright;
  logic [D-1:0]  grounds;
  logic [6:0]    display;
  logic          dp;
  logic          frame_start;

  sevenseg_scan #(
    .DIGITS   (D),
    .PRE_W    (PW),
    .BRIGHT_W (BW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .datain      (datain),
    .dp_in       (dp_in),
    .blank       (blank),
    .bright      (bright),
    .grounds     (grounds),
    .display     (display),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] font_ref [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference model state
  int           k;                 // enabled clock edges since reset
  int           last_edge;         // index of the edge just evaluated
  logic [3:0]   m_nib [D];
  logic [D-1:0] m_dp;
  logic [D-1:0] m_blank;
  logic [D-1:0] m_mask;
  logic [D-1:0] e_g;
  logic [6:0]   e_disp;
  logic         e_dp;
  logic         e_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib_of(input logic [4*D-1:0] d, input int i);
    logic [4*D-1:0] s;
    s = d >> (4 * (D - 1 - i));
    return s[3:0];
  endfunction

  // Leading-zero mask: count zero nibbles from digit 0, stopping before the
  // last digit.
  function automatic logic [D-1:0] lz_ref(input logic [4*D-1:0] d);
    int n;
    n = 0;
`ifdef SEVENSEG_LZB_EN
    while (n < D - 1 && nib_of(d, n) == 4'h0) n++;
`endif
    return D'((1 << n) - 1);
  endfunction

  // One clock: evaluate the model at the edge, compare pins 1 time unit later,
  // return at the following falling edge so callers can change inputs.
  task automatic step();
    int slot, dig;
    bit on;
    @(posedge clk);
    if (!rst_n) begin
      e_g = '1; e_disp = '0; e_dp = 1'b0; e_fs = 1'b0;
      k = 0;
      for (int i = 0; i < D; i++) m_nib[i] = '0;
      m_dp = '0; m_blank = '0; m_mask = '0;
      last_edge = -1;
    end else begin
      slot = k % SLOT;
      dig  = (k / SLOT) % D;
      on   = (slot != 0) && (slot / STEP <= int'(bright))
          && !m_blank[dig] && !m_mask[dig];
      e_g    = '1;
      if (on) e_g[D-1-dig] = 1'b0;
      e_disp = on ? font_ref[m_nib[dig]] : 7'd0;
      e_dp   = on & m_dp[dig];
      e_fs   = (slot == 0) && (dig == 0);
      if (e_fs) begin
        for (int i = 0; i < D; i++) m_nib[i] = nib_of(datain, i);
        m_dp    = dp_in;
        m_blank = blank;
        m_mask  = lz_ref(datain);
      end
      last_edge = k;
      k++;
    end
    #1;
    check("grounds", 32'(grounds), 32'(e_g));
    check("display", 32'(display), 32'(e_disp));
    check("dp", 32'(dp), 32'(e_dp));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    @(negedge clk);
  endtask

  int cnt_a, cnt_b;

  initial begin
    rst_n  = 1'b0;
    datain = 16'h12AF;
    dp_in  = '0;
    blank  = '0;
    bright = 2'd3;
    @(negedge clk);
    step();
    step();
    check("rst_grounds", 32'(grounds), 32'hF);
    check("rst_display", 32'(display), 32'h0);

    // Scan order and snapshot coherence: datain is zeroed mid-frame.
    rst_n = 1'b1;
    cnt_a = 0;
    for (int c = 0; c < 128; c++) begin
      if (k == 20) datain = 16'h0000;
      step();
      if (frame_start) cnt_a++;
      if (last_edge == 21) begin
        check("scan_d1_g", 32'(grounds), 32'b1011);
        check("scan_d1_seg", 32'(display), 32'b1101101);
      end
      if (last_edge == 53) begin
        check("coh_d3_g", 32'(grounds), 32'b1110);
        check("coh_d3_seg", 32'(display), 32'b1000111);
      end
      if (last_edge == 69) begin
        check("new_d0_seg", 32'(display), 32'b1111110);
      end
    end
    check("frame_count", 32'(cnt_a), 32'd2);

    // Brightness 0: 3 lit clocks per slot, 12 per frame.
    bright = 2'd0;
    datain = 16'h8888;
    cnt_a  = 0;
    for (int c = 0; c < SLOT * D; c++) begin
      step();
      if (grounds != '1) cnt_a++;
    end
    check("dim_on_cycles", 32'(cnt_a), 32'd12);

    // Blank digit 2, decimal point on digit 0.
    bright = 2'd3;
    datain = 16'h12AF;
    blank  = 4'b0100;
    dp_in  = 4'b0001;
    cnt_a  = 0;
    cnt_b  = 0;
    for (int c = 0; c < 2 * SLOT * D; c++) begin
      step();
      if (last_edge > 256 && !grounds[1]) cnt_a++;
      if (dp && grounds != 4'b0111) cnt_b++;
    end
    check("blank_d2", 32'(cnt_a), 32'd0);
    check("dp_only_d0", 32'(cnt_b), 32'd0);

    // Reset in the middle of digit 2.
    for (int c = 0; c < 200 && ((k / SLOT) % D != 2 || k % SLOT != 6); c++) step();
    check("reached_d2", 32'((k / SLOT) % D), 32'd2);
    rst_n = 1'b0;
    step();
    check("midrst_g", 32'(grounds), 32'hF);
    check("midrst_seg", 32'(display), 32'h0);
    rst_n  = 1'b1;
    datain = 16'h5000;
    blank  = '0;
    step();
    check("restart_fs", 32'(frame_start), 32'd1);
    step();
    check("restart_d0_g", 32'(grounds), 32'b0111);
    check("restart_d0_seg", 32'(display), 32'b1011011);

    // Leading zeros (blanked only when the build option is on).
    datain = 16'h0030;
    dp_in  = 4'b1111;
    for (int c = 0; c < 2 * SLOT * D; c++) step();
    datain = 16'h0000;
    dp_in  = 4'b0000;
    for (int c = 0; c < 2 * SLOT * D; c++) step();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(7) == 0)   datain = 16'($urandom);
      if ($urandom_range(15) == 0)  dp_in  = 4'($urandom);
      if ($urandom_range(15) == 0)  blank  = 4'($urandom);
      if ($urandom_range(3) == 0)   bright = 2'($urandom);
      if ($urandom_range(15) == 0)  datain[15:8] = 8'h00;
      rst_n = ($urandom_range(299) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
